// File: rtl/mem_write_checker.sv
// Self-checking monitor for the data-memory write port: classifies scalar and
// vector stores, enforces a run timeout and latches a sticky verdict.
module mem_write_checker #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int LANES      = 5,
   parameter int PASS_ADDR  = 100,
   parameter int PASS_DATA  = 7,
   parameter int ALLOW_ADDR = 96,
   parameter int VEC_CHECK  = 1,
   parameter int TIMEOUT    = 1000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         mem_write,
   input  logic [ADDR_W-1:0]            data_adr,
   input  logic [DATA_W-1:0]            write_data,
   input  logic [LANES*DATA_W-1:0]      vec_write_data,
   input  logic [LANES*DATA_W-1:0]      vec_expect,
   input  logic [LANES-1:0]             lane_mask,
   output logic                         done,
   output logic                         pass,
   output logic [2:0]                   fail_code,
   output logic [ADDR_W-1:0]            fail_adr,
   output logic [DATA_W-1:0]            fail_data,
   output logic [LANES-1:0]             fail_lane,
   output logic [15:0]                  write_count,
   output logic [$clog2(TIMEOUT+1)-1:0] cycle_count
);

   localparam int CYC_W = $clog2(TIMEOUT+1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] PASS = 2'd2;
   localparam logic [1:0] FAIL = 2'd3;

   localparam logic [2:0] CODE_NONE    = 3'd0;
   localparam logic [2:0] CODE_ILLEGAL = 3'd1;
   localparam logic [2:0] CODE_DATA    = 3'd2;
   localparam logic [2:0] CODE_VECTOR  = 3'd3;
   localparam logic [2:0] CODE_TIMEOUT = 3'd4;

   localparam logic [ADDR_W-1:0] PASS_ADR_C  = ADDR_W'(PASS_ADDR);
   localparam logic [ADDR_W-1:0] ALLOW_ADR_C = ADDR_W'(ALLOW_ADDR);
   localparam logic [DATA_W-1:0] PASS_DAT_C  = DATA_W'(PASS_DATA);
   localparam logic [CYC_W-1:0]  TIMEOUT_C   = CYC_W'(TIMEOUT);

   function automatic logic [15:0] satInc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [1:0]       state;
   logic [LANES-1:0] laneMiss;
   logic [LANES-1:0] badLanes;
   logic             vecBad;
   logic [CYC_W-1:0] cycleNext;
   logic             timeoutHit;
   logic             goPass;
   logic             goFail;
   logic [2:0]       nextCode;

   always_comb begin
      laneMiss = '0;
      for (int i = 0; i < LANES; i++) begin
         laneMiss[i] = (vec_write_data[i*DATA_W +: DATA_W] != vec_expect[i*DATA_W +: DATA_W]);
      end
   end

   assign badLanes   = laneMiss & lane_mask;
   assign vecBad     = (VEC_CHECK != 0) && (|badLanes);
   assign cycleNext  = cycle_count + CYC_W'(1);
   assign timeoutHit = (cycleNext == TIMEOUT_C);

   // Store classification first; the timeout only applies when no store decided the edge.
   always_comb begin
      goPass   = 1'b0;
      goFail   = 1'b0;
      nextCode = CODE_NONE;
      if (mem_write) begin
         if (data_adr == ALLOW_ADR_C) begin
            goFail = 1'b0;
         end else if (data_adr == PASS_ADR_C) begin
            if (write_data != PASS_DAT_C) begin
               goFail   = 1'b1;
               nextCode = CODE_DATA;
            end else if (vecBad) begin
               goFail   = 1'b1;
               nextCode = CODE_VECTOR;
            end else begin
               goPass = 1'b1;
            end
         end else begin
            goFail   = 1'b1;
            nextCode = CODE_ILLEGAL;
         end
      end
      if (!goPass && !goFail && timeoutHit) begin
         goFail   = 1'b1;
         nextCode = CODE_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_code   <= CODE_NONE;
         fail_adr    <= '0;
         fail_data   <= '0;
         fail_lane   <= '0;
         write_count <= '0;
         cycle_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) state <= RUN;
            end
            RUN: begin
               if (en) begin
                  cycle_count <= cycleNext;
                  if (mem_write) write_count <= satInc(write_count);
                  if (goPass) begin
                     state <= PASS;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else if (goFail) begin
                     state     <= FAIL;
                     done      <= 1'b1;
                     fail_code <= nextCode;
                     if (nextCode != CODE_TIMEOUT) begin
                        fail_adr  <= data_adr;
                        fail_data <= write_data;
                     end
                     if (nextCode == CODE_VECTOR) fail_lane <= badLanes;
                  end
               end
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: two instances share stimulus, one with
// lane checking enabled and one with it disabled, both with a short timeout.
module tb_mem_write_checker;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int LANES  = 5;
   localparam int TMO    = 10;
   localparam int CYC_W  = $clog2(TMO+1);

   logic                    clk = 1'b0;
   logic                    reset, en, memWrite;
   logic [ADDR_W-1:0]       dataAdr;
   logic [DATA_W-1:0]       writeData;
   logic [LANES*DATA_W-1:0] vecWr, vecExp;
   logic [LANES-1:0]        laneMask;

   logic                done0, pass0, done1, pass1;
   logic [2:0]          code0, code1;
   logic [ADDR_W-1:0]   fadr0, fadr1;
   logic [DATA_W-1:0]   fdata0, fdata1;
   logic [LANES-1:0]    flane0, flane1;
   logic [15:0]         wc0, wc1;
   logic [CYC_W-1:0]    cc0, cc1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_write_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .PASS_ADDR(100),
      .PASS_DATA(7), .ALLOW_ADDR(96), .VEC_CHECK(1), .TIMEOUT(TMO)) u0 (
      .clk(clk), .reset(reset), .en(en), .mem_write(memWrite), .data_adr(dataAdr),
      .write_data(writeData), .vec_write_data(vecWr), .vec_expect(vecExp),
      .lane_mask(laneMask), .done(done0), .pass(pass0), .fail_code(code0),
      .fail_adr(fadr0), .fail_data(fdata0), .fail_lane(flane0),
      .write_count(wc0), .cycle_count(cc0));

   mem_write_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .PASS_ADDR(100),
      .PASS_DATA(7), .ALLOW_ADDR(96), .VEC_CHECK(0), .TIMEOUT(TMO)) u1 (
      .clk(clk), .reset(reset), .en(en), .mem_write(memWrite), .data_adr(dataAdr),
      .write_data(writeData), .vec_write_data(vecWr), .vec_expect(vecExp),
      .lane_mask(laneMask), .done(done1), .pass(pass1), .fail_code(code1),
      .fail_adr(fadr1), .fail_data(fdata1), .fail_lane(flane1),
      .write_count(wc1), .cycle_count(cc1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      reset    = 1'b0;
      en       = 1'b0;
      memWrite = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      memWrite  = 1'b1;
      dataAdr   = a;
      writeData = d;
      tick();
      memWrite = 1'b0;
   endtask

   task automatic checkZero(input string tag);
      check({tag, ".done"}, 64'(done0), 64'd0);
      check({tag, ".pass"}, 64'(pass0), 64'd0);
      check({tag, ".code"}, 64'(code0), 64'd0);
      check({tag, ".fadr"}, 64'(fadr0), 64'd0);
      check({tag, ".fdata"}, 64'(fdata0), 64'd0);
      check({tag, ".flane"}, 64'(flane0), 64'd0);
      check({tag, ".wc"}, 64'(wc0), 64'd0);
      check({tag, ".cc"}, 64'(cc0), 64'd0);
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; memWrite = 1'b0;
      dataAdr = '0; writeData = '0; laneMask = 5'b11111;
      for (int i = 0; i < LANES; i++) vecExp[i*DATA_W +: DATA_W] = 32'(i + 10);
      vecWr = vecExp;

      // Reset state, then allowed store followed by the passing store
      doReset();
      checkZero("rst");
      en = 1'b1;
      tick();
      check("idle2run.cc", 64'(cc0), 64'd0);
      store(96, 32'h1234);
      check("allow.done", 64'(done0), 64'd0);
      check("allow.wc", 64'(wc0), 64'd1);
      store(100, 7);
      check("pass.done", 64'(done0), 64'd1);
      check("pass.pass", 64'(pass0), 64'd1);
      check("pass.code", 64'(code0), 64'd0);
      check("pass.wc", 64'(wc0), 64'd2);
      check("pass.cc", 64'(cc0), 64'd2);
      check("pass.fadr", 64'(fadr0), 64'd0);
      store(64, 7);
      check("sticky.pass", 64'(pass0), 64'd1);
      check("sticky.code", 64'(code0), 64'd0);
      check("sticky.wc", 64'(wc0), 64'd2);
      check("sticky.cc", 64'(cc0), 64'd2);

      // Reset from PASS
      reset = 1'b0;
      tick();
      checkZero("rstPass");
      reset = 1'b1;

      // Bad pass data
      en = 1'b1;
      tick();
      store(100, 8);
      check("bad.done", 64'(done0), 64'd1);
      check("bad.pass", 64'(pass0), 64'd0);
      check("bad.code", 64'(code0), 64'd2);
      check("bad.fadr", 64'(fadr0), 64'd100);
      check("bad.fdata", 64'(fdata0), 64'd8);

      // Illegal address, verdict then frozen
      doReset();
      en = 1'b1;
      tick();
      store(64, 7);
      check("ill.code", 64'(code0), 64'd1);
      check("ill.fadr", 64'(fadr0), 64'd64);
      check("ill.fdata", 64'(fdata0), 64'd7);
      store(100, 7);
      check("illFrz.code", 64'(code0), 64'd1);
      check("illFrz.pass", 64'(pass0), 64'd0);
      check("illFrz.fadr", 64'(fadr0), 64'd64);
      check("illFrz.wc", 64'(wc0), 64'd1);

      // Lane mismatch on lanes 2 and 4 with only lanes 1,2 masked in
      doReset();
      vecWr[2*DATA_W +: DATA_W] = 32'hDEAD;
      vecWr[4*DATA_W +: DATA_W] = 32'hBEEF;
      laneMask = 5'b00110;
      en = 1'b1;
      tick();
      store(100, 7);
      check("vec.code", 64'(code0), 64'd3);
      check("vec.flane", 64'(flane0), 64'b00100);
      check("vec.fadr", 64'(fadr0), 64'd100);
      check("vec.fdata", 64'(fdata0), 64'd7);
      check("vecOff.pass", 64'(pass1), 64'd1);
      check("vecOff.code", 64'(code1), 64'd0);
      check("vecOff.flane", 64'(flane1), 64'd0);

      // Mismatching lanes but empty mask
      doReset();
      laneMask = 5'b00000;
      en = 1'b1;
      tick();
      store(100, 7);
      check("mask0.pass", 64'(pass0), 64'd1);
      check("mask0.code", 64'(code0), 64'd0);
      vecWr = vecExp;
      laneMask = 5'b11111;

      // Timeout with no stores
      doReset();
      en = 1'b1;
      tick();
      repeat (9) tick();
      check("tmo9.done", 64'(done0), 64'd0);
      check("tmo9.cc", 64'(cc0), 64'd9);
      tick();
      check("tmo.done", 64'(done0), 64'd1);
      check("tmo.pass", 64'(pass0), 64'd0);
      check("tmo.code", 64'(code0), 64'd4);
      check("tmo.cc", 64'(cc0), 64'd10);
      check("tmo.fadr", 64'(fadr0), 64'd0);
      check("tmo.fdata", 64'(fdata0), 64'd0);
      check("tmo1.code", 64'(code1), 64'd4);

      // Passing store on the timeout edge
      doReset();
      en = 1'b1;
      tick();
      repeat (9) tick();
      store(100, 7);
      check("tmoPass.pass", 64'(pass0), 64'd1);
      check("tmoPass.code", 64'(code0), 64'd0);
      check("tmoPass.cc", 64'(cc0), 64'd10);

      // Pause for 5 cycles mid-run delays the timeout and ignores stores
      doReset();
      en = 1'b1;
      tick();
      repeat (4) tick();
      en = 1'b0;
      memWrite = 1'b1;
      dataAdr = 64;
      writeData = 1;
      repeat (5) tick();
      memWrite = 1'b0;
      check("pause.cc", 64'(cc0), 64'd4);
      check("pause.wc", 64'(wc0), 64'd0);
      check("pause.done", 64'(done0), 64'd0);
      en = 1'b1;
      repeat (5) tick();
      check("resume.cc", 64'(cc0), 64'd9);
      check("resume.done", 64'(done0), 64'd0);
      tick();
      check("pauseTmo.code", 64'(code0), 64'd4);
      check("pauseTmo.cc", 64'(cc0), 64'd10);

      // Reset mid-RUN, then a normal rerun
      doReset();
      en = 1'b1;
      tick();
      store(96, 3);
      check("mid.wc", 64'(wc0), 64'd1);
      reset = 1'b0;
      tick();
      checkZero("rstMid");
      reset = 1'b1;
      tick();
      check("reIdle.cc", 64'(cc0), 64'd0);
      tick();
      check("reRun.cc", 64'(cc0), 64'd1);
      store(100, 7);
      check("rerun.pass", 64'(pass0), 64'd1);
      check("rerun.wc", 64'(wc0), 64'd1);
      check("rerun.cc", 64'(cc0), 64'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
